// File: rtl/snake_move_ctrl_if.sv
// Signal bundle between the snake head sequencer and the rest of the game.
// The sequencer side uses the slave modport; the board/player side uses master.
interface snake_move_ctrl_if;
    logic              start;
    logic              pause;
    logic              L;
    logic              R;
    logic              U;
    logic              D;
    logic              body_hit;
    logic [2:0]        next_x;
    logic [2:0]        next_y;
    logic [7:0][7:0]   head_position;
    logic              tracking;
    logic              snake;
    logic              game_over;
    logic [1:0]        dir;
    logic [7:0]        move_count;

    modport master (
        output start, pause, L, R, U, D, body_hit,
        input  next_x, next_y, head_position, tracking,
        input  snake, game_over, dir, move_count
    );

    modport slave (
        input  start, pause, L, R, U, D, body_hit,
        output next_x, next_y, head_position, tracking,
        output snake, game_over, dir, move_count
    );
endinterface

// File: rtl/snake_move_ctrl.sv
// Snake head sequencer: move ticks, direction latch, head stepping, game over.
// Define SNAKE_MOVE_WRAP_EN for a toroidal board (no wall collisions).
module snake_move_ctrl #(
    parameter int TICK_DIV = 8,
    parameter int START_X  = 0,
    parameter int START_Y  = 0
) (
    input  logic               Clock,
    input  logic               reset,
    snake_move_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, OVER} state_t;

    localparam logic [1:0] D_R = 2'd0;
    localparam logic [1:0] D_L = 2'd1;
    localparam logic [1:0] D_U = 2'd2;
    localparam logic [1:0] D_D = 2'd3;

    localparam logic [2:0] SX  = 3'(START_X);
    localparam logic [2:0] SY  = 3'(START_Y);
    localparam logic [7:0] TOP = 8'(TICK_DIV - 1);

`ifdef SNAKE_MOVE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    state_t     state_q, state_d;
    logic [2:0] hx_q, hx_d;
    logic [2:0] hy_q, hy_d;
    logic [1:0] dir_q, dir_d;
    logic [1:0] pend_q, pend_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] moves_q, moves_d;
    logic       track_q, track_d;

    logic [2:0] cx, cy;
    logic       at_edge;
    logic       wall;
    logic       tick;
    logic       btn_any;
    logic [1:0] btn;
    logic       latch;

    // Candidate cell; 3-bit arithmetic already wraps modulo 8.
    always_comb begin
        cx      = hx_q;
        cy      = hy_q;
        at_edge = 1'b0;
        unique case (pend_q)
            D_R: begin
                at_edge = (hx_q == 3'd7);
                cx      = hx_q + 3'd1;
            end
            D_L: begin
                at_edge = (hx_q == 3'd0);
                cx      = hx_q - 3'd1;
            end
            D_U: begin
                at_edge = (hy_q == 3'd0);
                cy      = hy_q - 3'd1;
            end
            D_D: begin
                at_edge = (hy_q == 3'd7);
                cy      = hy_q + 3'd1;
            end
        endcase
        wall = at_edge & ~WRAP;
        if (wall) begin
            cx = hx_q;
            cy = hy_q;
        end
    end

    // Button priority L > R > U > D; reversals against the applied dir drop.
    always_comb begin
        btn_any = bus.L | bus.R | bus.U | bus.D;
        btn     = D_D;
        if (bus.L)
            btn = D_L;
        else if (bus.R)
            btn = D_R;
        else if (bus.U)
            btn = D_U;
        latch = btn_any && (btn != (dir_q ^ 2'b01));
    end

    assign tick = (state_q == RUN) && !bus.pause && (cnt_q == TOP);

    always_ff @(posedge Clock) begin
        if (reset) begin
            state_q <= IDLE;
            hx_q    <= SX;
            hy_q    <= SY;
            dir_q   <= D_R;
            pend_q  <= D_R;
            cnt_q   <= '0;
            moves_q <= '0;
            track_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hx_q    <= hx_d;
            hy_q    <= hy_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            moves_q <= moves_d;
            track_q <= track_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hx_d    = hx_q;
        hy_d    = hy_q;
        dir_d   = dir_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        moves_d = moves_q;
        track_d = 1'b0;
        unique case (state_q)
            IDLE, OVER: begin
                cnt_d = '0;
                if (bus.start) begin
                    state_d = RUN;
                    hx_d    = SX;
                    hy_d    = SY;
                    dir_d   = D_R;
                    pend_d  = D_R;
                    moves_d = '0;
                end
            end
            RUN: begin
                if (latch)
                    pend_d = btn;
                if (tick) begin
                    cnt_d = '0;
                    if (wall || bus.body_hit) begin
                        state_d = OVER;
                    end else begin
                        hx_d    = cx;
                        hy_d    = cy;
                        dir_d   = pend_q;
                        track_d = 1'b1;
                        if (moves_q != 8'hFF)
                            moves_d = moves_q + 8'd1;
                    end
                end else begin
                    // Pause on the tick cycle holds the counter at TOP.
                    if (cnt_q != TOP)
                        cnt_d = cnt_q + 8'd1;
                    if (bus.pause)
                        state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (latch)
                    pend_d = btn;
                if (!bus.pause)
                    state_d = RUN;
            end
        endcase
    end

    always_comb begin
        bus.head_position             = '0;
        bus.head_position[hy_q][hx_q] = 1'b1;
    end

    assign bus.next_x     = cx;
    assign bus.next_y     = cy;
    assign bus.tracking   = track_q;
    assign bus.snake      = (state_q == RUN) || (state_q == PAUSE);
    assign bus.game_over  = (state_q == OVER);
    assign bus.dir        = dir_q;
    assign bus.move_count = moves_q;

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Bench for snake_move_ctrl: game-rule model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_snake_move_ctrl;
    localparam int TD = 4;
    localparam int MI = 0;
    localparam int MR = 1;
    localparam int MP = 2;
    localparam int MO = 3;
`ifdef SNAKE_MOVE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic Clock = 1'b0;
    logic reset = 1'b0;

    snake_move_ctrl_if bus();

    snake_move_ctrl #(
        .TICK_DIV(TD),
        .START_X (0),
        .START_Y (0)
    ) dut (
        .Clock(Clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 Clock = ~Clock;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Game-level model: mode, head coordinates, directions, move phase.
    int m_mode, m_x, m_y, m_dir, m_pend, m_cnt, m_moves;
    bit m_track;
    bit m_valid = 1'b0;

    function automatic int step_x(input int d);
        case (d)
            0: return 1;
            1: return -1;
            default: return 0;
        endcase
    endfunction

    function automatic int step_y(input int d);
        case (d)
            2: return -1;
            3: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int opposite(input int d);
        case (d)
            0: return 1;
            1: return 0;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    task automatic cand(output int cx, output int cy, output bit wall);
        cx   = m_x + step_x(m_pend);
        cy   = m_y + step_y(m_pend);
        wall = (cx < 0) || (cx > 7) || (cy < 0) || (cy > 7);
        if (WRAP) begin
            cx   = (cx + 8) % 8;
            cy   = (cy + 8) % 8;
            wall = 1'b0;
        end else if (wall) begin
            cx = m_x;
            cy = m_y;
        end
    endtask

    task automatic home();
        m_x = 0; m_y = 0; m_dir = 0; m_pend = 0; m_cnt = 0; m_moves = 0;
    endtask

    always @(posedge Clock) begin : model
        int cx, cy, b, old_dir;
        bit wall, tick;
        m_track = 1'b0;
        if (reset) begin
            m_valid = 1'b1;
            m_mode  = MI;
            home();
        end else if (m_mode == MI || m_mode == MO) begin
            m_cnt = 0;
            if (bus.start) begin
                m_mode = MR;
                home();
            end
        end else begin
            cand(cx, cy, wall);
            old_dir = m_dir;
            b = bus.L ? 1 : bus.R ? 0 : bus.U ? 2 : bus.D ? 3 : -1;
            tick = (m_mode == MR) && !bus.pause && (m_cnt == TD - 1);
            if (tick) begin
                m_cnt = 0;
                if (wall || bus.body_hit) begin
                    m_mode = MO;
                end else begin
                    m_x = cx;
                    m_y = cy;
                    m_dir = m_pend;
                    m_moves = (m_moves < 255) ? m_moves + 1 : 255;
                    m_track = 1'b1;
                end
            end else if (m_mode == MR) begin
                if (m_cnt < TD - 1) m_cnt++;
                if (bus.pause) m_mode = MP;
            end else if (!bus.pause) begin
                m_mode = MR;
            end
            if (b >= 0 && b != opposite(old_dir)) m_pend = b;
        end
    end

    always @(negedge Clock) begin : compare
        int cx, cy;
        bit wall;
        logic [63:0] hp;
        if (m_valid) begin
            hp = 64'd1 << (m_y * 8 + m_x);
            chk("snake", 64'(bus.snake), 64'(m_mode == MR || m_mode == MP));
            chk("game_over", 64'(bus.game_over), 64'(m_mode == MO));
            chk("tracking", 64'(bus.tracking), 64'(m_track));
            chk("dir", 64'(bus.dir), 64'(m_dir));
            chk("move_count", 64'(bus.move_count), 64'(m_moves));
            chk("head_position", bus.head_position, hp);
            if (m_mode == MR || m_mode == MP) begin
                cand(cx, cy, wall);
                chk("next_x", 64'(bus.next_x), 64'(cx));
                chk("next_y", 64'(bus.next_y), 64'(cy));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge Clock);
        #1;
    endtask

    // {start, pause, L, R, U, D}; each held three cycles
    logic [5:0] vec [16] = '{
        6'b100000, 6'b000001, 6'b000000, 6'b000100,
        6'b001000, 6'b000010, 6'b010000, 6'b010010,
        6'b000001, 6'b001100, 6'b000011, 6'b000000,
        6'b100000, 6'b000001, 6'b000101, 6'b000000
    };

    initial begin
        {bus.start, bus.pause, bus.L, bus.R, bus.U, bus.D, bus.body_hit} = '0;

        reset = 1'b1;
        cyc(2);
        chk("rst_snake", 64'(bus.snake), 64'd0);
        chk("rst_head", bus.head_position, 64'h1);
        chk("rst_moves", 64'(bus.move_count), 64'd0);
        reset = 1'b0;

        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        chk("run_snake", 64'(bus.snake), 64'd1);
        cyc(3);
        chk("pre_tick_track", 64'(bus.tracking), 64'd0);
        cyc(1);
        chk("tick1_track", 64'(bus.tracking), 64'd1);
        chk("tick1_head", bus.head_position, 64'h2);
        chk("tick1_moves", 64'(bus.move_count), 64'd1);
        chk("tick1_dir", 64'(bus.dir), 64'd0);

        bus.L = 1'b1;
        cyc(4);
        bus.L = 1'b0;
        chk("rev_head", bus.head_position, 64'h4);
        chk("rev_dir", 64'(bus.dir), 64'd0);
        bus.D = 1'b1;
        cyc(1);
        bus.D = 1'b0;
        cyc(3);
        chk("down_head", bus.head_position, 64'h400);
        chk("down_dir", 64'(bus.dir), 64'd3);
        chk("down_moves", 64'(bus.move_count), 64'd3);

        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        bus.U = 1'b1;
        cyc(1);
        bus.U = 1'b0;
        cyc(3);
`ifdef SNAKE_MOVE_WRAP_EN
        chk("wrap_head", bus.head_position, 64'h1 << 56);
        chk("wrap_track", 64'(bus.tracking), 64'd1);
        chk("wrap_over", 64'(bus.game_over), 64'd0);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
`else
        chk("wall_over", 64'(bus.game_over), 64'd1);
        chk("wall_snake", 64'(bus.snake), 64'd0);
        chk("wall_head", bus.head_position, 64'h1);
        chk("wall_track", 64'(bus.tracking), 64'd0);
`endif
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        chk("restart_snake", 64'(bus.snake), 64'd1);
        chk("restart_moves", 64'(bus.move_count), 64'd0);
        chk("restart_head", bus.head_position, 64'h1);

        cyc(15);
        bus.body_hit = 1'b1;
        cyc(1);
        bus.body_hit = 1'b0;
        chk("body_over", 64'(bus.game_over), 64'd1);
        chk("body_head", bus.head_position, 64'h8);
        chk("body_moves", 64'(bus.move_count), 64'd3);

        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        cyc(1);
        bus.pause = 1'b1;
        cyc(10);
        bus.pause = 1'b0;
        cyc(2);
        chk("pause_early_track", 64'(bus.tracking), 64'd0);
        chk("pause_early_moves", 64'(bus.move_count), 64'd0);
        cyc(1);
        chk("pause_tick_track", 64'(bus.tracking), 64'd1);
        chk("pause_tick_head", bus.head_position, 64'h2);

        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("mid_rst_snake", 64'(bus.snake), 64'd0);
        chk("mid_rst_head", bus.head_position, 64'h1);
        chk("mid_rst_moves", 64'(bus.move_count), 64'd0);
        chk("mid_rst_over", 64'(bus.game_over), 64'd0);
        chk("mid_rst_track", 64'(bus.tracking), 64'd0);

        foreach (vec[i]) begin
            {bus.start, bus.pause, bus.L, bus.R, bus.U, bus.D} = vec[i];
            cyc(3);
        end
        {bus.start, bus.pause, bus.L, bus.R, bus.U, bus.D} = '0;
        cyc(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/snake_move_ctrl.md
Name: snake_move_ctrl

Overview:
Sequencer for the Snake head datapath.
- Divides Clock into move ticks and latches the player's L/R/U/D input, rejecting reversals.
- Steps the head across the 8x8 board and ends the game on a wall or body collision.
- Drives the `snake`, `tracking` and `head_position` signals consumed by the collision/highlight logic.

Parameters:
- TICK_DIV, 8: Clock cycles per head move; legal range 2..255.
- START_X, 0: head column after start/restart, 0..7.
- START_Y, 0: head row after start/restart, 0..7.

Ports:
- Clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high; dominates all other inputs.
- start  in  1  level; begins a game from IDLE or OVER.
- pause  in  1  level; freezes the game while high in RUN.
- L, R, U, D  in  1 each  direction buttons; level, sampled every cycle.
- body_hit  in  1  combinational from body tracker: cell (next_x,next_y) is occupied; must be valid in the tick cycle.
- next_x, next_y  out  3 each  candidate head cell for the pending move.
- head_position  out  [7:0][7:0]  one-hot board; bit [y][x] set at the head cell.
- tracking  out  1  one-cycle pulse, coincident with each head update.
- snake  out  1  high in RUN and PAUSE.
- game_over  out  1  high in OVER.
- dir  out  2  applied direction: 0=R, 1=L, 2=U, 3=D.
- move_count  out  8  successful moves this game; saturates at 255.

Behaviour:
- Reset values (next edge after reset=1):
  - state IDLE.
  - head (START_X,START_Y); head_position has only that bit set.
  - dir=R, pending dir=R, tick counter 0, move_count 0.
  - tracking=0, snake=0, game_over=0.
- Reset mid-game: same values, one cycle later; no tracking pulse.
- Coordinates: x increases to the right (R:+1, L:-1); y increases downward (U:-1, D:+1).
- States and transitions:
  - IDLE -> RUN on start.
  - RUN -> PAUSE on pause.
  - PAUSE -> RUN on !pause.
  - RUN -> OVER on a collision at a tick.
  - OVER -> RUN on start.
  - start is ignored in RUN and PAUSE.
  - Every entry to RUN from IDLE or OVER reinitialises head, dir, pending dir, counter and move_count to reset values.
- Direction latch:
  - Active in RUN and PAUSE only.
  - If several buttons are high, priority is L > R > U > D.
  - A button opposite the applied dir is ignored; otherwise it overwrites pending dir.
  - A press in the tick cycle does not affect that tick's move; it applies from the next tick.
- Tick counter:
  - Increments each RUN cycle; holds in PAUSE; cleared in IDLE and OVER.
  - A tick occurs in the RUN cycle where counter==TICK_DIV-1; the counter wraps to 0 there.
  - The first tick is therefore the TICK_DIV-th RUN cycle.
  - A pause asserted in the tick cycle wins: no move, counter holds.
- next_x/next_y:
  - Combinational: head stepped one cell in pending dir.
  - Without WRAP_EN, a step off the board leaves the candidate equal to the head and raises an internal wall flag.
- At a tick:
  - If wall or body_hit: go to OVER; head, dir and move_count unchanged; tracking stays 0.
  - Otherwise on the next edge: head <= next; dir <= pending dir; move_count +1 (saturating); tracking=1 for exactly that cycle.
- head_position, tracking and game_over are registered; no combinational path from inputs.
- OVER: head_position and move_count are frozen; snake=0; game_over=1.

Optional Feature:
- Macro SNAKE_MOVE_WRAP_EN.
- Defined: board is toroidal; x/y wrap modulo 8 (e.g. x=7 moving R -> x=0); wall collision never occurs; only body_hit ends the game.
- Undefined: leaving 0..7 in either axis is a wall collision -> OVER as above.

Test Plan:
- TICK_DIV=4, start high 1 cycle from IDLE -> snake=1; head_position[0][0]=1; after 4 RUN cycles head (1,0), tracking pulses 1 cycle, move_count=1, dir=0.
- Running R, hold L across a tick -> L ignored; head (1,0)->(2,0); dir stays 0. Then press D -> next tick head (2,1), dir=3.
- Undefined WRAP_EN, head (0,0), press U, tick -> game_over=1, snake=0, head stays (0,0), no tracking. Start -> RUN at (0,0), move_count=0.
- Defined WRAP_EN, same stimulus -> head (0,7), tracking pulse, game_over=0.
- body_hit=1 in tick cycle at head (3,0) dir R -> OVER; head_position[0][3] remains set; move_count unchanged.
- Pause 10 cycles mid-count, then release -> tick occurs exactly 10 cycles later than without pause. Reset asserted 1 cycle in RUN -> IDLE with all reset values next cycle.
